// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush bubbles, memory-wait and ex-hold stalls.
// Optional memory-wait watchdog is enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, WAIT_MEM, HOLD} state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  flush_cnt_reg, flush_cnt_next;

    logic        jump_en_c;
    logic [31:0] jump_addr_c;
    logic        hold_pc_c;
    logic        stall_c;
    logic        flush_c;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
    logic        err_c;
`endif

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        jump_en_c      = 1'b0;
        jump_addr_c    = '0;
        hold_pc_c      = 1'b0;
        stall_c        = 1'b0;
        flush_c        = 1'b0;
`ifdef PIPE_CTRL_TIMEOUT_EN
        tmo_cnt_next   = tmo_cnt_reg;
        err_c          = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (jump_en_i) begin
                    jump_en_c   = 1'b1;
                    jump_addr_c = jump_addr_i;
                    flush_c     = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_LOAD;
                    end
                end else if (mem_req_i) begin
                    hold_pc_c  = 1'b1;
                    stall_c    = 1'b1;
                    state_next = WAIT_MEM;
`ifdef PIPE_CTRL_TIMEOUT_EN
                    tmo_cnt_next = '0;
`endif
                end else if (hold_flag_i) begin
                    hold_pc_c  = 1'b1;
                    stall_c    = 1'b1;
                    state_next = HOLD;
                end
            end
            // Bubble cycles: upstream stages hold NOPs, so their requests are meaningless.
            FLUSH: begin
                flush_c        = 1'b1;
                flush_cnt_next = flush_cnt_reg - 2'd1;
                if (flush_cnt_reg == 2'd1) begin
                    state_next = IDLE;
                end
            end
            WAIT_MEM: begin
                hold_pc_c = 1'b1;
                stall_c   = 1'b1;
                if (mem_ack_i) begin
                    state_next = IDLE;
                end
`ifdef PIPE_CTRL_TIMEOUT_EN
                else if (tmo_cnt_reg == TMO_LAST) begin
                    err_c      = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
`endif
            end
            HOLD: begin
                hold_pc_c = hold_flag_i;
                stall_c   = hold_flag_i;
                if (!hold_flag_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= '0;
`ifdef PIPE_CTRL_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
`ifdef PIPE_CTRL_TIMEOUT_EN
            tmo_cnt_reg   <= tmo_cnt_next;
`endif
        end
    end

    // Outputs follow live inputs, so they are gated to stay quiet while reset is held.
    assign jump_en_o   = rst & jump_en_c;
    assign jump_addr_o = rst ? jump_addr_c : 32'd0;
    assign hold_pc_o   = rst & hold_pc_c;
    assign stall_o     = rst & stall_c;
    assign flush_o     = rst & flush_c;
    assign busy_o      = rst & (state_reg != IDLE);
`ifdef PIPE_CTRL_TIMEOUT_EN
    assign err_o       = rst & err_c;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a behavioural hazard model.
`timescale 1ns/100ps
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int TC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        hold_flag_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        stall_o;
    logic        flush_o;
    logic        busy_o;
    logic        err_o;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT_CYCLES(TC)) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .hold_flag_i (hold_flag_i),
        .mem_req_i   (mem_req_i),
        .mem_ack_i   (mem_ack_i),
        .jump_en_o   (jump_en_o),
        .jump_addr_o (jump_addr_o),
        .hold_pc_o   (hold_pc_o),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: remaining bubbles, an outstanding memory access with its age, an ex hold.
    int bubbles_left;
    bit mem_outstanding;
    int mem_age;
    bit ex_busy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        bubbles_left    = 0;
        mem_outstanding = 1'b0;
        mem_age         = 0;
        ex_busy         = 1'b0;
    endtask

    function automatic logic [31:0] pack_ctl(input bit j, input bit h, input bit s,
                                             input bit f, input bit b, input bit e);
        return {26'd0, j, h, s, f, b, e};
    endfunction

    task automatic step(input bit j, input logic [31:0] a, input bit mr, input bit hf,
                        input bit ack, input bit rst_pulse);
        bit e_j, e_h, e_s, e_f, e_b, e_e;
        logic [31:0] e_a;
        jump_en_i   = j;
        jump_addr_i = a;
        mem_req_i   = mr;
        hold_flag_i = hf;
        mem_ack_i   = ack;
        if (rst_pulse) begin
            #1 rst = 1'b0;
            #0.5;
            check_val("rst_async_ctl", pack_ctl(jump_en_o, hold_pc_o, stall_o, flush_o, busy_o, err_o), 32'd0);
            check_val("rst_async_addr", jump_addr_o, 32'd0);
            #0.5 rst = 1'b1;
            model_reset();
        end
        @(negedge clk);
        e_j = 0; e_a = 32'd0; e_h = 0; e_s = 0; e_f = 0; e_e = 0;
        e_b = (bubbles_left > 0) || mem_outstanding || ex_busy;
        if (bubbles_left > 0) begin
            e_f = 1;
            bubbles_left--;
        end else if (mem_outstanding) begin
            e_h = 1; e_s = 1;
            if (ack) begin
                mem_outstanding = 1'b0;
            end else begin
`ifdef PIPE_CTRL_TIMEOUT_EN
                mem_age++;
                if (mem_age == TC) begin
                    e_e = 1;
                    mem_outstanding = 1'b0;
                end
`endif
            end
        end else if (ex_busy) begin
            e_h = hf; e_s = hf;
            if (!hf) ex_busy = 1'b0;
        end else if (j) begin
            e_j = 1; e_a = a; e_f = 1;
            bubbles_left = FC - 1;
        end else if (mr) begin
            e_h = 1; e_s = 1;
            mem_outstanding = 1'b1;
            mem_age = 0;
        end else if (hf) begin
            e_h = 1; e_s = 1;
            ex_busy = 1'b1;
        end
        check_val("ctl", pack_ctl(jump_en_o, hold_pc_o, stall_o, flush_o, busy_o, err_o),
                  pack_ctl(e_j, e_h, e_s, e_f, e_b, e_e));
        check_val("addr", jump_addr_o, e_a);
        check_val("stall_flush_excl", {31'd0, stall_o & flush_o}, 32'd0);
        $display("cyc %0d in j=%b a=%h mr=%b hf=%b ack=%b rp=%b out j=%b a=%h h=%b s=%b f=%b b=%b e=%b",
                 cyc, j, a, mr, hf, ack, rst_pulse, jump_en_o, jump_addr_o, hold_pc_o,
                 stall_o, flush_o, busy_o, err_o);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #2;
        check_val("reset_ctl", pack_ctl(jump_en_o, hold_pc_o, stall_o, flush_o, busy_o, err_o), 32'd0);
        check_val("reset_addr", jump_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 20; i++) step(0, 32'd0, 0, 0, 0, 0);

        step(1, 32'h0000_0100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'd0, 0, 0, 0, 0);

        step(0, 32'd0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'd0, 0, 0, 0, 0);
        step(0, 32'd0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 32'd0, 0, 0, 0, 0);

        step(1, 32'h0000_0200, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'd0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) step(0, 32'd0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 32'd0, 0, 0, 0, 0);

        step(0, 32'd0, 1, 0, 0, 0);
`ifdef PIPE_CTRL_TIMEOUT_EN
        for (int i = 0; i < 12; i++) step(0, 32'd0, 0, 0, 0, 0);
`else
        for (int i = 0; i < 300; i++) step(0, 32'd0, 0, 0, 0, 0);
`endif
        step(0, 32'd0, 0, 0, 1, 0);
        step(0, 32'd0, 0, 0, 0, 0);

        step(0, 32'd0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 32'd0, 0, 0, 0, 0);
        step(0, 32'd0, 0, 0, 0, 1);
        step(0, 32'd0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 32'd0, 0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
